key_debounce_20ms: RTL and testbench

Debounces and edge-detects the car-control push buttons, using the 50 Hz square wave from the 20 ms divider as its sampling time base. It sits directly downstream of the divider and upstream of the car motion/steering logic. For each key it produces:
- a clean level;
- one-cycle press and release pulses;
- auto-repeat pulses while the key is held.

---
 rtl/car_input_pkg.sv | 21 ++
 rtl/key_channel.sv | 114 +++++++++++
 rtl/key_debounce_20ms.sv | 49 ++++
 tb/tb_key_debounce_20ms.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/car_input_pkg.sv
// Shared types and constants for the car-control push-button front end.
package car_input_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD      = 2'd1,
    REPEATING = 2'd2
  } key_state_e;

  localparam int unsigned KEY_UP     = 0;
  localparam int unsigned KEY_DOWN   = 1;
  localparam int unsigned KEY_LEFT   = 2;
  localparam int unsigned KEY_RIGHT  = 3;
  localparam int unsigned KEY_CENTER = 4;

  localparam int unsigned DEF_NKEYS        = 5;
  localparam int unsigned DEF_STABLE_TICKS = 3;
  localparam int unsigned DEF_REPEAT_DELAY = 25;
  localparam int unsigned DEF_REPEAT_RATE  = 5;

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchronizer, tick-sampled debounce, and the
// press/release/auto-repeat FSM with registered one-cycle pulses.
module key_channel
  import car_input_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_en,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);

  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned SW     = $clog2(STABLE_TICKS + 1);
  localparam int unsigned RW     = $clog2(RptMax + 1);

  logic          r_sync1, r_keys_s;
  logic [SW-1:0] r_stab_cnt, w_stab_cnt_d, w_stab_inc;
  logic          r_level, w_level_d, w_accept;
  key_state_e    r_state, w_state_d;
  logic [RW-1:0] r_rpt_cnt, w_rpt_cnt_d, w_rpt_dec;
  logic          r_press, r_release, r_repeat;
  logic          w_press_d, w_release_d, w_repeat_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_keys_s   <= 1'b0;
      r_stab_cnt <= '0;
      r_level    <= 1'b0;
      r_state    <= IDLE;
      r_rpt_cnt  <= '0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_repeat   <= 1'b0;
    end else begin
      r_sync1    <= key_raw;
      r_keys_s   <= r_sync1;
      r_stab_cnt <= w_stab_cnt_d;
      r_level    <= w_level_d;
      r_state    <= w_state_d;
      r_rpt_cnt  <= w_rpt_cnt_d;
      r_press    <= w_press_d;
      r_release  <= w_release_d;
      r_repeat   <= w_repeat_d;
    end
  end

  // A level change is accepted on the STABLE_TICKS-th consecutive differing sample.
  always_comb begin
    w_stab_inc   = r_stab_cnt + 1'b1;
    w_stab_cnt_d = r_stab_cnt;
    w_accept     = 1'b0;
    if (tick_en) begin
      if (r_keys_s == r_level) begin
        w_stab_cnt_d = '0;
      end else if (w_stab_inc == SW'(STABLE_TICKS)) begin
        w_accept     = 1'b1;
        w_stab_cnt_d = '0;
      end else begin
        w_stab_cnt_d = w_stab_inc;
      end
    end
    w_level_d = r_level ^ w_accept;
  end

  always_comb begin
    w_state_d   = r_state;
    w_rpt_cnt_d = r_rpt_cnt;
    w_press_d   = 1'b0;
    w_release_d = 1'b0;
    w_repeat_d  = 1'b0;
    w_rpt_dec   = r_rpt_cnt - 1'b1;
    unique case (r_state)
      IDLE: begin
        if (w_accept && !r_level) begin
          w_state_d   = HELD;
          w_press_d   = 1'b1;
          w_rpt_cnt_d = RW'(REPEAT_DELAY);
        end
      end
      HELD, REPEATING: begin
        // Release is checked first so it wins over a coincident repeat expiry.
        if (w_accept && r_level) begin
          w_state_d   = IDLE;
          w_release_d = 1'b1;
          w_rpt_cnt_d = '0;
        end else if (tick_en) begin
          if (w_rpt_dec == '0) begin
            w_state_d   = REPEATING;
            w_repeat_d  = 1'b1;
            w_rpt_cnt_d = RW'(REPEAT_RATE);
          end else begin
            w_rpt_cnt_d = w_rpt_dec;
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  assign key_level   = r_level;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign key_repeat  = r_repeat;

endmodule

// File: rtl/key_debounce_20ms.sv
// Debounce/edge-detect/auto-repeat for NKEYS buttons, sampled on rising
// edges of the 20 ms square wave (used as data, never as a clock).
module key_debounce_20ms
  import car_input_pkg::*;
#(
  parameter int unsigned NKEYS        = DEF_NKEYS,
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_clk,
  input  logic [NKEYS-1:0] keys_in,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release,
  output logic [NKEYS-1:0] key_repeat
);

  logic r_tick_d;
  logic w_tick_en;

  // tick_clk comes from clk's own divider, so no synchronizer is needed.
  always_ff @(posedge clk) begin
    if (rst) r_tick_d <= 1'b0;
    else     r_tick_d <= tick_clk;
  end

  assign w_tick_en = tick_clk & ~r_tick_d;

  for (genvar g = 0; g < int'(NKEYS); g++) begin : gen_keys
    key_channel #(
      .STABLE_TICKS(STABLE_TICKS),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_key_channel (
      .clk        (clk),
      .rst        (rst),
      .tick_en    (w_tick_en),
      .key_raw    (keys_in[g]),
      .key_level  (key_level[g]),
      .key_press  (key_press[g]),
      .key_release(key_release[g]),
      .key_repeat (key_repeat[g])
    );
  end

endmodule

// File: tb/tb_key_debounce_20ms.sv
// Directed plus randomized bench; expected outputs come from a tick-level
// model built on sample streaks and hold-time arithmetic.
module tb_key_debounce_20ms;
  import car_input_pkg::*;

  localparam int NK   = 5;
  localparam int ST   = 3;
  localparam int DLY  = 4;
  localparam int RATE = 2;

  logic          clk = 1'b0;
  logic          rst, tick_clk;
  logic [NK-1:0] keys_in, key_level, key_press, key_release, key_repeat;

  int total = 0;
  int bad   = 0;

  logic [NK-1:0] m_lvl;
  int            streak [NK];
  int            held_t [NK];
  logic [NK-1:0] last_press, last_release, last_repeat;

  always #5 clk = ~clk;

  key_debounce_20ms #(
    .NKEYS       (NK),
    .STABLE_TICKS(ST),
    .REPEAT_DELAY(DLY),
    .REPEAT_RATE (RATE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_clk   (tick_clk),
    .keys_in    (keys_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_repeat (key_repeat)
  );

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lvl = '0;
    for (int i = 0; i < NK; i++) begin
      streak[i] = 0;
      held_t[i] = 0;
    end
  endtask

  task automatic do_reset(input logic [NK-1:0] k);
    @(negedge clk);
    keys_in  = k;
    tick_clk = 1'b0;
    rst      = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("reset_outputs", 12'(key_level | key_press | key_release | key_repeat), 12'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One 20-clk tick period: keys settle during the low half, then one rising edge.
  task automatic run_tick(input logic [NK-1:0] k, input string tag);
    logic [NK-1:0] ep, er, et;
    logic          acc;
    ep = '0;
    er = '0;
    et = '0;
    keys_in = k;
    repeat (10) @(negedge clk);
    tick_clk = 1'b1;
    for (int i = 0; i < NK; i++) begin
      acc = 1'b0;
      if (k[i] != m_lvl[i]) streak[i]++;
      else                  streak[i] = 0;
      if (streak[i] == ST) begin
        acc       = 1'b1;
        streak[i] = 0;
        m_lvl[i]  = ~m_lvl[i];
      end
      if (acc) begin
        if (m_lvl[i]) begin
          ep[i]     = 1'b1;
          held_t[i] = 0;
        end else begin
          er[i] = 1'b1;
        end
      end else if (m_lvl[i]) begin
        held_t[i]++;
        if (held_t[i] >= DLY && (held_t[i] - DLY) % RATE == 0) et[i] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    last_press   = key_press;
    last_release = key_release;
    last_repeat  = key_repeat;
    check({tag, "_level"},   12'(key_level),   12'(m_lvl));
    check({tag, "_press"},   12'(key_press),   12'(ep));
    check({tag, "_release"}, 12'(key_release), 12'(er));
    check({tag, "_repeat"},  12'(key_repeat),  12'(et));
    @(posedge clk);
    #1;
    check({tag, "_pulse_width"}, 12'(key_press | key_release | key_repeat), 12'(0));
    repeat (8) @(negedge clk);
    tick_clk = 1'b0;
  endtask

  initial begin
    logic [NK-1:0] rk;
    logic [NK-1:0] pulses_or;
    logic [12:1]   hist;

    rst      = 1'b0;
    tick_clk = 1'b0;
    keys_in  = '0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset with all keys held, then acceptance on the 3rd tick.
    do_reset(5'b11111);
    repeat (3) run_tick(5'b11111, "rst_hold");
    check("rst_press_all", 12'(last_press), 12'(5'b11111));
    repeat (3) run_tick(5'b00000, "rst_rel");
    check("rst_release_all", 12'(last_release), 12'(5'b11111));

    // Clean press on key 0.
    repeat (3) run_tick(5'b00001, "clean");
    check("clean_press", 12'({last_press, last_release}), 12'({5'b00001, 5'b00000}));
    run_tick(5'b00001, "clean_hold");
    repeat (3) run_tick(5'b00000, "clean_rel");

    // Bounce on key 2: 1,0,1,1,0 never reaches three equal differing samples.
    pulses_or = '0;
    run_tick(5'b00100, "bounce");
    pulses_or |= last_press | last_release | last_repeat;
    run_tick(5'b00000, "bounce");
    pulses_or |= last_press | last_release | last_repeat;
    repeat (2) begin
      run_tick(5'b00100, "bounce");
      pulses_or |= last_press | last_release | last_repeat;
    end
    repeat (3) begin
      run_tick(5'b00000, "bounce");
      pulses_or |= last_press | last_release | last_repeat;
    end
    check("bounce_level", 12'(key_level[KEY_LEFT]), 12'(0));
    check("bounce_pulses", 12'(pulses_or), 12'(0));

    // Auto-repeat on key 1, then release accepted exactly on a repeat tick.
    repeat (3) run_tick(5'b00010, "rpt_acc");
    hist = '0;
    for (int t = 1; t <= 13; t++) begin
      run_tick(5'b00010, "rpt_hold");
      if (t <= 12) hist[t] = last_repeat[KEY_DOWN];
    end
    check("repeat_schedule", 12'(hist), 12'b1010_1010_1000);
    repeat (3) run_tick(5'b00000, "collide");
    check("collide_rel_wins", 12'({last_release[KEY_DOWN], last_repeat[KEY_DOWN]}), 12'(2'b10));
    repeat (2) run_tick(5'b00000, "after_collide");
    repeat (9) run_tick(5'b00010, "rpt_again");
    repeat (3) run_tick(5'b00000, "rpt_again_rel");

    // Simultaneous press/release of keys 1 and 3.
    repeat (3) run_tick(5'b01010, "simul");
    check("simul_press", 12'(last_press), 12'(5'b01010));
    repeat (3) run_tick(5'b00000, "simul_rel");
    check("simul_release", 12'(last_release), 12'(5'b01010));

    // Stuck tick: keys wiggle but nothing may change.
    run_tick(5'b10000, "pre_stuck");
    repeat (3) run_tick(5'b10000, "pre_stuck");
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      keys_in = NK'($urandom);
      @(posedge clk);
      #1;
      check("stuck", 12'({key_press | key_release | key_repeat, key_level}), 12'({5'b0, m_lvl}));
    end

    // Reset mid-operation with keys held, then fresh acceptance.
    repeat (8) run_tick(5'b11111, "pre_midrst");
    do_reset(5'b11111);
    repeat (3) run_tick(5'b11111, "midrst");
    check("midrst_press", 12'(last_press), 12'(5'b11111));
    repeat (3) run_tick(5'b00000, "midrst_rel");

    // Randomized traffic: each key flips with probability 1/6 per tick.
    rk = '0;
    for (int t = 0; t < 150; t++) begin
      for (int i = 0; i < NK; i++) begin
        if ($urandom_range(0, 5) == 0) rk[i] = ~rk[i];
      end
      run_tick(rk, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
